// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, start/stop validation,
// a show-ahead receive FIFO and sticky, CPU-clearable overrun/framing flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  input  logic       uart_err_clr_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_ovr_o,
  output logic       uart_ferr_o,
  output logic       uart_busy_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ZERO  = (AW + 1)'(0);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer and edge-detect history
  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Receiver FSM state
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_busy;

  // FIFO storage and pointers (one extra bit separates full from empty)
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  // Sticky error flags
  logic r_ovr;
  logic r_ferr;

  // Combinational decode
  logic        w_fall;
  logic        w_stop_sample;
  logic        w_push;
  logic        w_ferr_set;
  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr_en;
  logic        w_ovr_set;

  // Line is "falling" only when the previous synchronized sample was high,
  // so a line held low (break) never starts a frame.
  assign w_fall        = r_prev & ~r_sync2;
  assign w_stop_sample = (r_state == STOP) && (r_cnt == BIT_LAST);
  assign w_push        = w_stop_sample & r_sync2;
  assign w_ferr_set    = w_stop_sample & ~r_sync2;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_count == PTR_ZERO);
  assign w_full    = (w_count == DEPTH);
  assign w_pop     = uart_rd_i & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still succeeds when the head is being read.
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;

  // Two-flop synchronizer on the serial line plus a history flop for edges
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Frame FSM: half-bit start qualification, 8 LSB-first data bits, stop check
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            if (!r_sync2) begin
              r_state <= DATA;
              r_cnt   <= CNT_ZERO;
              r_idx   <= 3'd0;
            end else begin
              // Line went back high before mid-start: treat as a glitch
              r_state <= IDLE;
              r_cnt   <= CNT_ZERO;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= CNT_ZERO;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= CNT_ZERO;
          r_idx   <= 3'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Receive FIFO: write completed bytes, advance read pointer on CPU pop
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Sticky error flags; a set on the same edge as a clear takes priority
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (uart_err_clr_i) begin
        r_ovr <= 1'b0;
      end else begin
        r_ovr <= r_ovr;
      end
      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (uart_err_clr_i) begin
        r_ferr <= 1'b0;
      end else begin
        r_ferr <= r_ferr;
      end
    end
  end

  assign uart_dat_o   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign uart_valid_o = ~w_empty;
  assign uart_ovr_o   = r_ovr;
  assign uart_ferr_o  = r_ferr;
  assign uart_busy_o  = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a queue-based model of
// the receiver (received-byte list plus two sticky flags).
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rd;
  logic       clr;
  logic [7:0] dat;
  logic       valid;
  logic       ovr;
  logic       ferr;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int first_valid;

  // Reference model: bytes the CPU can still read, and the sticky flags
  logic [7:0] m_q[$];
  logic       m_ovr;
  logic       m_ferr;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk_i      (clk),
    .sys_rst_i      (rst),
    .uart_rx_i      (rx),
    .uart_rd_i      (rd),
    .uart_err_clr_i (clr),
    .uart_dat_o     (dat),
    .uart_valid_o   (valid),
    .uart_ovr_o     (ovr),
    .uart_ferr_o    (ferr),
    .uart_busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // A complete frame reaches the model: good stop -> store if room, else overrun
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic model_pop();
    if (m_q.size() > 0) void'(m_q.pop_front());
  endtask

  task automatic check_model(input string tag);
    logic [7:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 8'h00;
    check({tag, ".dat"},   {24'd0, dat},   {24'd0, head});
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, (m_q.size() > 0)});
    check({tag, ".ovr"},   {31'd0, ovr},   {31'd0, m_ovr});
    check({tag, ".ferr"},  {31'd0, ferr},  {31'd0, m_ferr});
  endtask

  // Drive ncyc cycles of one 8N1 frame; optionally pulse rd on cycle rd_at
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int ncyc, input int rd_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    first_valid = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rx = bits[i / CPB];
      rd = (i == rd_at);
      if (valid && first_valid < 0) first_valid = i;
    end
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic do_read(input string tag);
    check_model(tag);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    model_pop();
  endtask

  task automatic clear_errors();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic saw_busy;
    logic [7:0] rb;
    logic rstop;
    int nrd;

    rst = 1'b1; rx = 1'b1; rd = 1'b0; clr = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (3) @(negedge clk);
    check_model("reset");
    check("reset.busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Single byte with latency bound
    drive_frame(8'h55, 1'b1, 10 * CPB, -1);
    model_frame(8'h55, 1'b1);
    check("single.latency_ok", {31'd0, (first_valid >= 0 && first_valid <= 2 + 8 + CPB * 9 + 2)}, 32'd1);
    check_model("single");
    check("single.busy", {31'd0, busy}, 32'd0);
    do_read("single.rd");
    check_model("single.after_rd");

    // Glitch rejection: 4-cycle low pulse
    saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rx = (i < 4) ? 1'b0 : 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    check("glitch.saw_busy", {31'd0, saw_busy}, 32'd1);
    check("glitch.busy_end", {31'd0, busy}, 32'd0);
    check_model("glitch");

    // Framing error then a held-low line that must not start a frame
    drive_frame(8'hA3, 1'b0, 10 * CPB, -1);
    model_frame(8'hA3, 1'b0);
    saw_busy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rx = 1'b0;
      if (busy) saw_busy = 1'b1;
    end
    check("break.no_busy", {31'd0, saw_busy}, 32'd0);
    idle(4);
    check_model("ferr");
    clear_errors();
    check_model("ferr.cleared");

    // Overrun: five frames back to back, no reads
    for (int k = 1; k <= 5; k++) begin
      drive_frame(k[7:0], 1'b1, 10 * CPB, -1);
      model_frame(k[7:0], 1'b1);
    end
    idle(4);
    check_model("ovr");
    for (int k = 0; k < 4; k++) do_read("ovr.rd");
    check_model("ovr.drained");
    clear_errors();

    // Full FIFO with a pop on the exact push cycle of the fifth byte
    for (int k = 0; k < 4; k++) begin
      drive_frame(8'h10 + k[7:0], 1'b1, 10 * CPB, -1);
      model_frame(8'h10 + k[7:0], 1'b1);
    end
    drive_frame(8'h14, 1'b1, 10 * CPB, 154);
    model_pop();
    model_frame(8'h14, 1'b1);
    idle(4);
    check_model("fullpop");
    for (int k = 0; k < 4; k++) do_read("fullpop.rd");
    check_model("fullpop.drained");

    // Randomized frames, stop errors and reads against the model
    for (int k = 0; k < 8; k++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      drive_frame(rb, rstop, 10 * CPB, -1);
      model_frame(rb, rstop);
      idle(3);
      check_model("rand");
      nrd = $urandom_range(0, 2);
      for (int j = 0; j < nrd; j++) do_read("rand.rd");
    end
    clear_errors();
    check_model("rand.cleared");

    // Reset in the middle of a frame, after data bit 3
    drive_frame(8'h5A, 1'b1, 10 * CPB, -1);
    model_frame(8'h5A, 1'b1);
    idle(3);
    drive_frame(8'hFF, 1'b1, 5 * CPB, -1);
    rst = 1'b1;
    #1;
    m_q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    check_model("midrst");
    check("midrst.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    check_model("midrst.released");
    drive_frame(8'hC3, 1'b1, 10 * CPB, -1);
    model_frame(8'hC3, 1'b1);
    idle(4);
    check_model("midrst.c3");
    do_read("midrst.rd");
    check_model("midrst.empty");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
